// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), the timing record type and the
// total-period helpers used by the raster generator.
package vga_pkg;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_PULSE_DEF   = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_PULSE_DEF   = 2;
    localparam int V_BP_DEF      = 33;

    typedef struct packed {
        int unsigned display;
        int unsigned fp;
        int unsigned pulse;
        int unsigned bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    function automatic int unsigned h_total(vga_timing_t t);
        return t.h.display + t.h.fp + t.h.pulse + t.h.bp;
    endfunction

    function automatic int unsigned v_total(vga_timing_t t);
        return t.v.display + t.v.fp + t.v.pulse + t.v.bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Enable-gated shift register that lines sync/blank up with the downstream
// pixel pipeline; every stage clears to zero on reset.
module sync_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: x/y/frame counters stepped by pix_en,
// delayed sync/blank flags and one-clock line/frame strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_PULSE   = H_PULSE_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_PULSE   = V_PULSE_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int CNT_W     = 10,
    parameter int PIPE_DLY  = 2,
    parameter int FRAME_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               blank_n,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam vga_timing_t TIMING = '{
        h: '{display: H_DISPLAY, fp: H_FP, pulse: H_PULSE, bp: H_BP},
        v: '{display: V_DISPLAY, fp: V_FP, pulse: V_PULSE, bp: V_BP}
    };
    localparam int H_TOTAL = int'(h_total(TIMING));
    localparam int V_TOTAL = int'(v_total(TIMING));

    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_cnt_w_err
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end
    if (PIPE_DLY < 1) begin : g_dly_err
        $error("vga_timing_gen: PIPE_DLY must be at least 1");
    end

    // Window bounds carry one extra bit so a display width of 2^CNT_W still compares correctly.
    localparam logic [CNT_W:0] X_DE_END = (CNT_W+1)'(H_DISPLAY);
    localparam logic [CNT_W:0] X_HS_BEG = (CNT_W+1)'(H_DISPLAY + H_FP);
    localparam logic [CNT_W:0] X_HS_END = (CNT_W+1)'(H_DISPLAY + H_FP + H_PULSE);
    localparam logic [CNT_W:0] Y_DE_END = (CNT_W+1)'(V_DISPLAY);
    localparam logic [CNT_W:0] Y_VS_BEG = (CNT_W+1)'(V_DISPLAY + V_FP);
    localparam logic [CNT_W:0] Y_VS_END = (CNT_W+1)'(V_DISPLAY + V_FP + V_PULSE);
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic HS_LVL = (HS_POL != 0);
    localparam logic VS_LVL = (VS_POL != 0);

    logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               line_q, line_d, frm_q, frm_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
            line_q  <= 1'b0;
            frm_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            line_q  <= line_d;
            frm_q   <= frm_d;
        end
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        line_d  = 1'b0;
        frm_d   = 1'b0;
        if (pix_en) begin
            if (x_q == X_LAST) begin
                x_d    = '0;
                line_d = 1'b1;
                if (y_q == Y_LAST) begin
                    y_d     = '0;
                    frame_d = frame_q + 1'b1;
                    frm_d   = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    logic [CNT_W:0] xw, yw;
    logic           de, hs_act, vs_act;
    logic [2:0]     flags_dly;

    assign xw     = {1'b0, x_q};
    assign yw     = {1'b0, y_q};
    assign de     = (xw < X_DE_END) && (yw < Y_DE_END);
    assign hs_act = (xw >= X_HS_BEG) && (xw < X_HS_END);
    assign vs_act = (yw >= Y_VS_BEG) && (yw < Y_VS_END);

    sync_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_DLY)
    ) u_dly (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (pix_en),
        .data_i ({hs_act, vs_act, de}),
        .data_o (flags_dly)
    );

    assign x           = x_q;
    assign y           = y_q;
    assign frame_cnt   = frame_q;
    assign line_start  = line_q;
    assign frame_start = frm_q;
    assign hsync       = flags_dly[2] ? HS_LVL : ~HS_LVL;
    assign vsync       = flags_dly[1] ? VS_LVL : ~VS_LVL;
    assign video_on    = flags_dly[0];
    assign blank_n     = flags_dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a reduced instance
// share stimulus; an arithmetic step-count model is compared every cycle.
module tb_vga_timing_gen;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    logic [9:0]  a_x, a_y;
    logic [15:0] a_fc;
    logic        a_hs, a_vs, a_von, a_bn, a_ls, a_fs;
    logic [3:0]  b_x, b_y;
    logic [1:0]  b_fc;
    logic        b_hs, b_vs, b_von, b_bn, b_ls, b_fs;

    vga_timing_gen #(.PIPE_DLY(2)) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en), .x(a_x), .y(a_y),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .blank_n(a_bn),
        .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FP(2), .H_PULSE(2), .H_BP(2),
        .V_DISPLAY(4), .V_FP(1), .V_PULSE(1), .V_BP(1),
        .HS_POL(1), .VS_POL(0), .CNT_W(4), .PIPE_DLY(1), .FRAME_W(2)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en), .x(b_x), .y(b_y),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .blank_n(b_bn),
        .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    int total = 0;
    int bad   = 0;

    // Model state: number of pix_en steps since reset, and whether the last clk had pix_en.
    longint n   = 0;
    bit     pen = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n   <= 0;
            pen <= 1'b0;
        end else begin
            pen <= pix_en;
            if (pix_en) n <= n + 1;
        end
    end

    typedef struct packed {
        logic [31:0] x, y, fc;
        logic        hs, vs, de, ls, fs;
    } exp_t;

    function automatic exp_t model(input longint n_, input bit pen_,
                                   input int hd, hf, hp, hb, vd, vf, vp, vb, dly, fw,
                                   input bit hpol, vpol);
        exp_t   e;
        longint ht, vt, m, mx, my;
        bit     hs, vs, de;
        ht   = hd + hf + hp + hb;
        vt   = vd + vf + vp + vb;
        e.x  = 32'(n_ % ht);
        e.y  = 32'((n_ / ht) % vt);
        e.fc = 32'((n_ / (ht * vt)) % (longint'(1) << fw));
        m  = n_ - dly;
        hs = 1'b0; vs = 1'b0; de = 1'b0;
        if (m >= 0) begin
            mx = m % ht;
            my = (m / ht) % vt;
            de = (mx < hd) && (my < vd);
            hs = (mx >= hd + hf) && (mx < hd + hf + hp);
            vs = (my >= vd + vf) && (my < vd + vf + vp);
        end
        e.hs = hs ? hpol : !hpol;
        e.vs = vs ? vpol : !vpol;
        e.de = de;
        e.ls = pen_ && (n_ > 0) && (e.x == 0);
        e.fs = e.ls && (e.y == 0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tg, input exp_t e,
                       input logic [31:0] x, y, fc,
                       input logic hs, vs, von, bn, ls, fs);
        chk({tg, "_x"},   x, e.x);
        chk({tg, "_y"},   y, e.y);
        chk({tg, "_fc"},  fc, e.fc);
        chk({tg, "_hs"},  32'(hs),  32'(e.hs));
        chk({tg, "_vs"},  32'(vs),  32'(e.vs));
        chk({tg, "_von"}, 32'(von), 32'(e.de));
        chk({tg, "_bn"},  32'(bn),  32'(e.de));
        chk({tg, "_ls"},  32'(ls),  32'(e.ls));
        chk({tg, "_fs"},  32'(fs),  32'(e.fs));
    endtask

    always @(negedge clk) begin
        cmp("a", model(n, pen, 640, 16, 96, 48, 480, 10, 2, 33, 2, 16, 1'b0, 1'b0),
            32'(a_x), 32'(a_y), 32'(a_fc), a_hs, a_vs, a_von, a_bn, a_ls, a_fs);
        cmp("b", model(n, pen, 8, 2, 2, 2, 4, 1, 1, 1, 1, 2, 1'b1, 1'b0),
            32'(b_x), 32'(b_y), 32'(b_fc), b_hs, b_vs, b_von, b_bn, b_ls, b_fs);
    end

    int cur = 0;
    task automatic adv_to(input int t);
        while (cur < t) begin
            @(posedge clk);
            cur++;
        end
        #2;
    endtask

    task automatic rst_pins(input string tg);
        chk({tg, "_a_x"},   32'(a_x), 0);
        chk({tg, "_a_y"},   32'(a_y), 0);
        chk({tg, "_a_fc"},  32'(a_fc), 0);
        chk({tg, "_a_hs"},  32'(a_hs), 1);
        chk({tg, "_a_vs"},  32'(a_vs), 1);
        chk({tg, "_a_von"}, 32'(a_von), 0);
        chk({tg, "_a_bn"},  32'(a_bn), 0);
        chk({tg, "_a_ls"},  32'(a_ls), 0);
        chk({tg, "_a_fs"},  32'(a_fs), 0);
        chk({tg, "_b_hs"},  32'(b_hs), 0);
        chk({tg, "_b_vs"},  32'(b_vs), 1);
        chk({tg, "_b_x"},   32'(b_x), 0);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1 rst_pins("rst0");

        repeat (3) @(posedge clk);
        #2;
        reset  = 1'b1;
        pix_en = 1'b1;
        cur    = 0;

        adv_to(1);   chk("a_x_first", 32'(a_x), 1); chk("a_von_n1", 32'(a_von), 0);
        adv_to(2);   chk("a_von_n2", 32'(a_von), 1); chk("a_bn_n2", 32'(a_bn), 1);
        adv_to(10);  chk("b_hs_n10", 32'(b_hs), 0);
        adv_to(11);  chk("b_hs_n11", 32'(b_hs), 1);
        adv_to(12);  chk("b_hs_n12", 32'(b_hs), 1);
        adv_to(13);  chk("b_hs_n13", 32'(b_hs), 0);
        adv_to(70);  chk("b_vs_n70", 32'(b_vs), 1);
        adv_to(71);  chk("b_vs_n71", 32'(b_vs), 0);
        adv_to(84);  chk("b_vs_n84", 32'(b_vs), 0);
        adv_to(85);  chk("b_vs_n85", 32'(b_vs), 1);
        adv_to(97);  chk("b_fc_n97", 32'(b_fc), 0);
        adv_to(98);  chk("b_fc_n98", 32'(b_fc), 1); chk("b_fs_n98", 32'(b_fs), 1);
                     chk("b_x_n98", 32'(b_x), 0);   chk("b_y_n98", 32'(b_y), 0);
        adv_to(99);  chk("b_fs_n99", 32'(b_fs), 0);
        adv_to(391); chk("b_fc_n391", 32'(b_fc), 3);
        adv_to(392); chk("b_fc_wrap", 32'(b_fc), 0); chk("b_fs_n392", 32'(b_fs), 1);
        adv_to(641); chk("a_von_n641", 32'(a_von), 1);
        adv_to(642); chk("a_von_n642", 32'(a_von), 0);
        adv_to(657); chk("a_hs_n657", 32'(a_hs), 1);
        adv_to(658); chk("a_hs_n658", 32'(a_hs), 0);
        adv_to(753); chk("a_hs_n753", 32'(a_hs), 0);
        adv_to(754); chk("a_hs_n754", 32'(a_hs), 1);
        adv_to(799); chk("a_x_n799", 32'(a_x), 799); chk("a_y_n799", 32'(a_y), 0);
        adv_to(800); chk("a_x_wrap", 32'(a_x), 0);   chk("a_y_inc", 32'(a_y), 1);
                     chk("a_ls_n800", 32'(a_ls), 1); chk("a_fs_n800", 32'(a_fs), 0);
        adv_to(801); chk("a_ls_n801", 32'(a_ls), 0);
        adv_to(1500);

        // Half-rate stepping: 200 pix_en edges over 400 clocks.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2 pix_en = ~pix_en;
        end

        for (int k = 0; k < 2000; k++) begin
            if (n % 800 == 300) break;
            @(posedge clk);
            #2;
        end
        chk("pre_rst_x", 32'(a_x), 300);
        chk("pre_rst_y", 32'(a_y), 2);
        reset = 1'b0;
        #1 rst_pins("rst_mid");

        repeat (4) @(posedge clk);
        #2;
        reset  = 1'b1;
        pix_en = 1'b1;
        repeat (300) @(posedge clk);
        #2;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2 pix_en = (i % 3 != 2);
        end
        pix_en = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
